// File: rtl/data_mem_ctrl.sv
// Byte/half/word little-endian data memory for the MEM stage with configurable
// wait states, Busy/Ready completion handshake and misalignment/range errors.
module data_mem_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LATENCY  = 0,
  parameter bit          INIT_IDX = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic [31:0] MemRes,
  output logic        Busy,
  output logic        Ready,
  output logic        Err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        fire;

  logic [31:0] a_q, wd_q;
  logic [1:0]  sz_q;
  logic        se_q, wr_q, rd_q;

  logic        req, idle;
  logic [31:0] a, wd;
  logic [1:0]  sz;
  logic        se, wr, rd;

  logic        err, we;
  logic [AW-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wdat, rword, shifted, ldval;
  logic [1:0]  lane;
  logic [31:0] words [DEPTH];

  assign req  = MemRead | MemWrite;
  assign idle = (state == IDLE);
  assign Busy = (state == WAIT);

  // With zero wait states the access uses the live request; otherwise the
  // operands captured at accept time.
  assign a  = idle ? Address   : a_q;
  assign wd = idle ? WriteData : wd_q;
  assign sz = idle ? Size      : sz_q;
  assign se = idle ? SignExt   : se_q;
  assign wr = idle ? MemWrite  : wr_q;
  assign rd = idle ? MemRead   : rd_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            fire = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          fire    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && idle && req) begin
      a_q  <= Address;
      wd_q <= WriteData;
      sz_q <= Size;
      se_q <= SignExt;
      wr_q <= MemWrite;
      rd_q <= MemRead;
    end
  end

  always_comb begin
    err = 1'b0;
    if (sz == 2'b11) err = 1'b1;
    if (sz == 2'b01 && a[0]) err = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) err = 1'b1;
    if ({2'b00, a[31:2]} >= 32'(DEPTH)) err = 1'b1;
  end

  assign widx = a[2 +: AW];
  assign we   = fire & ~rst & wr & ~err;

  always_comb begin
    be   = 4'b1111;
    wdat = wd;
    lane = 2'b00;
    case (sz)
      2'b00: begin
        be   = 4'b0001 << a[1:0];
        wdat = {4{wd[7:0]}};
        lane = a[1:0];
      end
      2'b01: begin
        be   = a[1] ? 4'b1100 : 4'b0011;
        wdat = {2{wd[15:0]}};
        lane = {a[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign rword   = words[widx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    case (sz)
      2'b00:   ldval = {{24{se & shifted[7]}}, shifted[7:0]};
      2'b01:   ldval = {{16{se & shifted[15]}}, shifted[15:0]};
      default: ldval = shifted;
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] w = INIT_IDX ? 32'(g) : '0;
    always_ff @(posedge clk) begin
      if (we && widx == AW'(g)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be[b]) w[8*b +: 8] <= wdat[8*b +: 8];
        end
      end
    end
    assign words[g] = w;
  end

  // A combined read+write request is a store; MemRes only moves on a clean load.
  always_ff @(posedge clk) begin
    if (rst) begin
      MemRes <= '0;
      Ready  <= 1'b0;
      Err    <= 1'b0;
    end else begin
      Ready <= fire;
      Err   <= fire & err;
      if (fire && rd && !wr && !err) MemRes <= ldval;
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the MIPS datapath: byte/halfword/word loads and stores, little-endian, with configurable wait-state latency. It reports completion through a Busy/Ready handshake and flags misaligned or out-of-range accesses. It sits in the MEM stage between the ALU address result and the write-back mux, and replaces the fixed word-only data memory.

## Interface
- DEPTH, 64: number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 0: wait states per access, 0..15.
- INIT_IDX, 1: 1 = mem[i] = i at time zero; 0 = all zero.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- Address  in  32  byte address; word index = Address[31:2], lane = Address[1:0].
- WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- SignExt  in  1  loads only: 1 sign-extend, 0 zero-extend.
- MemRes  out  32  registered load result, right-aligned and extended.
- Busy  out  1  access in progress; new requests ignored.
- Ready  out  1  one-cycle completion pulse.
- Err  out  1  valid with Ready; access was suppressed.

## Operation
- States: IDLE, WAIT. Busy = (state == WAIT).
- Accept: in IDLE, on an edge where MemRead or MemWrite = 1. Address, WriteData, Size, SignExt and the op are latched.
- If both MemRead and MemWrite are 1, the store is performed and the load is ignored. MemRes is unchanged, Err = 0.
- Error check at accept: Err = misaligned (half with Address[0]=1; word with Address[1:0]≠0), or Size=11, or Address[31:2] ≥ DEPTH. On error there is no memory write, MemRes holds its value, and Ready still pulses with Err=1.
- Stores write only the addressed lanes:
  - byte: lane Address[1:0] ← WriteData[7:0].
  - half: lanes {Address[1],1}/{Address[1],0} ← WriteData[15:0].
  - word: all four lanes.
  - Other lanes are preserved.
- Loads select the same lanes, shift to bit 0 and extend per SignExt. A word load ignores SignExt.
- LATENCY=0: the access is performed at the accept edge. State stays IDLE and Busy is never high.
- LATENCY=N>0: the accept edge loads cnt←N and enters WAIT.
  - Each WAIT edge decrements cnt.
  - On the edge where cnt==1, the access is performed, Ready←1 and state←IDLE.
- Requests arriving while Busy=1 are ignored, not queued. The master must hold or re-issue.
- Memory contents are not affected by rst.

## Timing
- Reset values: state IDLE, cnt 0, MemRes 0x00000000, Ready 0, Err 0, Busy 0.
- Request present in cycle 0 → Busy high in cycles 1..LATENCY → Ready/Err high in cycle LATENCY+1 only.
- A store commits at the same edge that raises Ready. A load issued in the Ready cycle sees the new data.
- MemRes changes only at a load-completion edge and then holds until the next successful load.
- A new request is accepted in the cycle Ready is high. Throughput is one access per LATENCY+1 cycles.
- rst during WAIT: the pending access is dropped (no write, no MemRes update, no Ready). Next cycle is IDLE.
- rst takes priority over a request on the same edge; that request is not accepted.

## Test plan
- LATENCY=0, after rst: lw 0x14 → Ready in cycle 1, MemRes=0x00000005, Err=0; Busy stays 0.
- sb 0xAB at 0x11, then:
  - lbu 0x11 → 0x000000AB.
  - lb 0x11 → 0xFFFFFFAB.
  - lw 0x10 → 0x0000AB04.
- sh 0x8001 at 0x22, then:
  - lw 0x20 → 0x80010008.
  - lh 0x22 → 0xFFFF8001.
  - lhu 0x22 → 0x00008001.
- Error cases, with DEPTH=64:
  - lw 0x06 → Ready=1, Err=1, MemRes unchanged.
  - sh 0x23 → Err=1; lw 0x20 is unchanged afterwards.
  - lw 0x100 → Err=1.
  - Size=11 → Err=1.
- LATENCY=3:
  - lw 0x08 in cycle 0 → Busy in cycles 1–3, Ready in cycle 4, MemRes=0x00000002.
  - A second request in cycle 2 is ignored.
  - Back-to-back requests issued in cycle 4 are accepted.
- LATENCY=3, sw 0xDEADBEEF at 0x0C, rst in cycle 2 → no Ready; a later lw 0x0C returns 0x00000003.
- MemRead and MemWrite both high, sw 0x12345678 at 0x04 → mem[1] written, MemRes unchanged, Err=0.
